rpc_tx_scheduler: RTL and testbench

Shares the single NIC UDP TX path among N_FLOWS RPC flow requesters, all in the app clock domain. Each flow pushes 512-bit NetworkPayload words into a private queue. A round-robin scheduler forwards one payload at a time on network_tx_out. Issue is gated by a credit counter that mirrors the free slots in the downstream TX async FIFO, and by a programmable inter-packet gap, so the FIFO never overflows and the 4-beat Avalon-ST packetiser is never outrun.

---
 rtl/rpc_tx_scheduler_pkg.sv | 16 +
 rtl/rpc_tx_scheduler_if.sv | 25 ++
 rtl/rpc_tx_scheduler_queue.sv | 49 ++++
 rtl/rpc_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_rpc_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpc_tx_scheduler_pkg.sv
// rtl/rpc_tx_scheduler_pkg.sv - shared payload/interface types and scheduler state encoding
package rpc_tx_scheduler_pkg;

    typedef logic [511:0] NetworkPayload;

    typedef struct packed {
        logic          valid;
        NetworkPayload payload;
    } NetworkIf;

    typedef enum logic [0:0] {
        SchIdle = 1'b0,
        SchGap  = 1'b1
    } SchedState;

endpackage

// File: rtl/rpc_tx_scheduler_if.sv
// rtl/rpc_tx_scheduler_if.sv - flow push, drop, credit-return and TX output bundle
interface rpc_tx_scheduler_if
    import rpc_tx_scheduler_pkg::*;
#(
    parameter int N_FLOWS = 4
);
    NetworkIf [N_FLOWS-1:0] flow_tx_in;
    logic     [N_FLOWS-1:0] flow_drop_out;
    NetworkIf               network_tx_out;
    logic                   credit_return_in;

    modport master (
        output flow_tx_in,
        output credit_return_in,
        input  flow_drop_out,
        input  network_tx_out
    );

    modport slave (
        input  flow_tx_in,
        input  credit_return_in,
        output flow_drop_out,
        output network_tx_out
    );
endinterface

// File: rtl/rpc_tx_scheduler_queue.sv
// rtl/rpc_tx_scheduler_queue.sv - per-flow synchronous payload FIFO
module tx_flow_queue
    import rpc_tx_scheduler_pkg::*;
#(
    parameter int LOG_Q_DEPTH = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  NetworkPayload push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output NetworkPayload head_o
);
    localparam int DEPTH = 2 ** LOG_Q_DEPTH;

    logic [LOG_Q_DEPTH-1:0] wr_q, rd_q;
    logic [LOG_Q_DEPTH:0]   count_q;
    NetworkPayload          mem_q [DEPTH];
    logic                   do_push, do_pop;

    // Fullness is taken from the registered count, so a pop in the same cycle never frees room.
    assign full_o  = count_q[LOG_Q_DEPTH];
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end
endmodule

// File: rtl/rpc_tx_scheduler.sv
// rtl/rpc_tx_scheduler.sv - round-robin, credit- and gap-gated scheduler onto the UDP TX path
module rpc_tx_scheduler
    import rpc_tx_scheduler_pkg::*;
#(
    parameter int N_FLOWS     = 4,
    parameter int LOG_Q_DEPTH = 3,
    parameter int CREDITS     = 16,
    parameter int GAP_W       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    rpc_tx_scheduler_if.slave        net_if,
    input  logic                     enable_in,
    input  logic [GAP_W-1:0]         gap_cfg_in,
    output logic [$clog2(CREDITS):0] credits_out,
    output logic [31:0]              tx_count_out,
    output logic                     credit_err_out
);
    localparam int LOG_N = $clog2(N_FLOWS);
    localparam int CW    = $clog2(CREDITS) + 1;

    logic [N_FLOWS-1:0] q_push, q_pop, q_full, q_empty;
    NetworkPayload      q_head [N_FLOWS];

    SchedState          state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LOG_N-1:0]   rr_q, grant_idx;
    logic               grant_valid, eligible;
    logic [CW-1:0]      credits_q, credits_d;
    logic               err_q, err_d;
    logic [31:0]        tx_count_q;
    logic               valid_q;
    NetworkPayload      payload_q;
    logic [N_FLOWS-1:0] drop_q;

    for (genvar g = 0; g < N_FLOWS; g++) begin : g_queue
        assign q_push[g] = net_if.flow_tx_in[g].valid;
        tx_flow_queue #(.LOG_Q_DEPTH(LOG_Q_DEPTH)) u_queue (
            .clk         (clk),
            .reset       (reset),
            .push_i      (q_push[g]),
            .push_data_i (net_if.flow_tx_in[g].payload),
            .pop_i       (q_pop[g]),
            .full_o      (q_full[g]),
            .empty_o     (q_empty[g]),
            .head_o      (q_head[g])
        );
    end

    // Circular search from rr_q+1; the index wraps for free because N_FLOWS is a power of two.
    always_comb begin
        logic [LOG_N-1:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = rr_q;
        q_pop       = '0;
        eligible    = (state_q == SchIdle) && enable_in && (credits_q != '0) && !(&q_empty);
        for (int k = 1; k <= N_FLOWS; k++) begin
            cand = rr_q + LOG_N'(k);
            if (eligible && !grant_valid && !q_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) q_pop[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            SchIdle: begin
                if (grant_valid && (gap_cfg_in != '0)) begin
                    state_d = SchGap;
                    gap_d   = gap_cfg_in;
                end
            end
            SchGap: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = SchIdle;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = SchIdle;
                gap_d   = '0;
            end
        endcase
    end

    // A return while already full is discarded and flagged; grant+return cancel out.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q | (net_if.credit_return_in && (credits_q == CW'(CREDITS)));
        case ({grant_valid, net_if.credit_return_in})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   if (credits_q != CW'(CREDITS)) credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SchIdle;
            gap_q      <= '0;
            rr_q       <= LOG_N'(N_FLOWS - 1);
            credits_q  <= CW'(CREDITS);
            err_q      <= 1'b0;
            tx_count_q <= '0;
            valid_q    <= 1'b0;
            payload_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            valid_q   <= grant_valid;
            drop_q    <= q_push & q_full;
            if (grant_valid) begin
                rr_q       <= grant_idx;
                payload_q  <= q_head[grant_idx];
                tx_count_q <= tx_count_q + 32'd1;
            end
        end
    end

    assign net_if.network_tx_out = NetworkIf'{valid: valid_q, payload: payload_q};
    assign net_if.flow_drop_out  = drop_q;
    assign credits_out           = credits_q;
    assign tx_count_out          = tx_count_q;
    assign credit_err_out        = err_q;
endmodule

// File: tb/tb_rpc_tx_scheduler.sv
// tb/tb_rpc_tx_scheduler.sv - directed bench with queue-level reference model for rpc_tx_scheduler
module tb_rpc_tx_scheduler;
    import rpc_tx_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int QD = 8;
    localparam int CR = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] gap = 4'd0;
    logic [4:0] credits;
    logic [31:0] tx_count;
    logic       credit_err;

    rpc_tx_scheduler_if #(.N_FLOWS(N)) ifc ();

    rpc_tx_scheduler #(.N_FLOWS(N), .LOG_Q_DEPTH(3), .CREDITS(CR), .GAP_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .net_if         (ifc),
        .enable_in      (enable),
        .gap_cfg_in     (gap),
        .credits_out    (credits),
        .tx_count_out   (tx_count),
        .credit_err_out (credit_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain queues, a credit integer and an earliest-next-grant cycle.
    NetworkPayload mq [N][$];
    int            credits_m = CR;
    logic [31:0]   txc_m = '0;
    bit            err_m = 1'b0;
    bit            ev_m = 1'b0;
    NetworkPayload ep_m = '0;
    logic [N-1:0]  ed_m = '0;
    int            rr_m = N - 1;
    longint        cyc = 0;
    longint        next_ok = 0;

    always @(posedge clk or posedge reset) begin
        bit grant;
        int g;
        int c;
        int idx;
        if (reset) begin
            for (int f = 0; f < N; f++) mq[f].delete();
            credits_m = CR; txc_m = '0; err_m = 1'b0; ev_m = 1'b0; ep_m = '0;
            ed_m = '0; rr_m = N - 1; next_ok = 0;
        end else begin
            cyc++;
            grant = 1'b0;
            g = 0;
            if (cyc >= next_ok && enable && credits_m > 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (rr_m + k) % N;
                    if (!grant && mq[idx].size() > 0) begin
                        grant = 1'b1;
                        g = idx;
                    end
                end
            end
            for (int f = 0; f < N; f++)
                ed_m[f] = ifc.flow_tx_in[f].valid && (mq[f].size() == QD);
            ev_m = grant;
            if (grant) begin
                ep_m = mq[g].pop_front();
                txc_m = txc_m + 1;
                rr_m = g;
                next_ok = cyc + gap + 1;
            end
            for (int f = 0; f < N; f++)
                if (ifc.flow_tx_in[f].valid && !ed_m[f]) mq[f].push_back(ifc.flow_tx_in[f].payload);
            if (ifc.credit_return_in && credits_m == CR) err_m = 1'b1;
            c = credits_m - int'(grant) + int'(ifc.credit_return_in);
            credits_m = (c > CR) ? CR : c;
        end
    end

    typedef struct {
        longint        c;
        NetworkPayload p;
    } ent_t;
    ent_t lg[$];
    int   drop_cnt = 0;

    always @(negedge clk) begin
        chk("valid", ifc.network_tx_out.valid, ev_m);
        chk("payload", ifc.network_tx_out.payload, ep_m);
        chk("drop", ifc.flow_drop_out, ed_m);
        chk("credits", credits, credits_m);
        chk("tx_count", tx_count, txc_m);
        chk("credit_err", credit_err, err_m);
        if (ifc.network_tx_out.valid) lg.push_back('{c: cyc, p: ifc.network_tx_out.payload});
        drop_cnt += $countones(ifc.flow_drop_out);
    end

    function automatic NetworkPayload mk(input int f, input int s);
        NetworkPayload p;
        p = '0;
        p[511:504] = 8'h5A;
        p[15:8] = 8'(f);
        p[7:0] = 8'(s);
        return p;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push1(input int f, input NetworkPayload p);
        ifc.flow_tx_in[f].valid = 1'b1;
        ifc.flow_tx_in[f].payload = p;
        idle(1);
        ifc.flow_tx_in[f].valid = 1'b0;
    endtask

    task automatic pulse_ret();
        ifc.credit_return_in = 1'b1;
        idle(1);
        ifc.credit_return_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        lg.delete();
        drop_cnt = 0;
    endtask

    task automatic wait_issued(input string nm, input int n, input int budget);
        int k = 0;
        while (lg.size() < n && k < budget) begin idle(1); k++; end
        chk(nm, lg.size(), n);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_valid"}, ifc.network_tx_out.valid, 1'b0);
        chk({nm, "_payload"}, ifc.network_tx_out.payload, '0);
        chk({nm, "_drop"}, ifc.flow_drop_out, 4'h0);
        chk({nm, "_credits"}, credits, 5'd16);
        chk({nm, "_tx_count"}, tx_count, 32'd0);
        chk({nm, "_err"}, credit_err, 1'b0);
    endtask

    initial begin
        NetworkPayload a5;
        a5 = {64{8'hA5}};
        ifc.flow_tx_in = '0;
        ifc.credit_return_in = 1'b0;
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: single push, output two cycles later
        push1(2, a5);
        @(negedge clk);
        chk("t1_valid_t1", ifc.network_tx_out.valid, 1'b0);
        @(negedge clk);
        chk("t1_valid_t2", ifc.network_tx_out.valid, 1'b1);
        chk("t1_payload", ifc.network_tx_out.payload, a5);
        chk("t1_tx_count", tx_count, 32'd1);
        chk("t1_credits", credits, 5'd15);
        @(posedge clk); #1;

        // 2: round robin over four flows
        do_reset();
        for (int s = 0; s < 2; s++) begin
            for (int f = 0; f < N; f++) begin
                ifc.flow_tx_in[f].valid = 1'b1;
                ifc.flow_tx_in[f].payload = mk(f, s);
            end
            idle(1);
            ifc.flow_tx_in = '0;
        end
        wait_issued("t2_issued", 8, 20);
        if (lg.size() >= 8)
            for (int i = 0; i < 8; i++) begin
                chk("t2_order", lg[i].p[15:8], 8'(i % 4));
                chk("t2_spacing", 64'(lg[i].c - lg[0].c), 64'(i));
            end
        idle(2);
        chk("t2_credits", credits, 5'd8);

        // 3: credit exhaustion, overflow drops, single return
        do_reset();
        for (int s = 0; s < 20; s++) push1(0, mk(0, s));
        idle(5);
        chk("t3_tx_stall", tx_count, 32'd16);
        chk("t3_credits0", credits, 5'd0);
        chk("t3_log16", lg.size(), 16);
        for (int s = 20; s < 26; s++) push1(0, mk(0, s));
        idle(2);
        chk("t3_drops", drop_cnt, 2);
        pulse_ret();
        idle(4);
        chk("t3_tx_one_more", tx_count, 32'd17);
        chk("t3_log17", lg.size(), 17);
        if (lg.size() >= 17) chk("t3_seq16", lg[16].p[7:0], 8'd16);

        // 4: inter-packet gap of 3
        do_reset();
        gap = 4'd3;
        for (int s = 0; s < 3; s++) push1(1, mk(1, s));
        wait_issued("t4_issued", 3, 30);
        if (lg.size() >= 3) begin
            chk("t4_space1", 64'(lg[1].c - lg[0].c), 64'd4);
            chk("t4_space2", 64'(lg[2].c - lg[1].c), 64'd4);
        end
        gap = 4'd0;

        // 5: grant with simultaneous return, then saturation
        do_reset();
        for (int s = 0; s < 11; s++) push1(0, mk(0, s));
        idle(3);
        chk("t5_credits5", credits, 5'd5);
        ifc.flow_tx_in[0].valid = 1'b1;
        ifc.flow_tx_in[0].payload = mk(0, 11);
        idle(1);
        ifc.flow_tx_in[0].valid = 1'b0;
        pulse_ret();
        chk("t5_credits_same", credits, 5'd5);
        idle(2);
        chk("t5_tx12", tx_count, 32'd12);
        for (int i = 0; i < 11; i++) pulse_ret();
        chk("t5_credits_full", credits, 5'd16);
        chk("t5_err_clear", credit_err, 1'b0);
        pulse_ret();
        chk("t5_credits_sat", credits, 5'd16);
        chk("t5_err_set", credit_err, 1'b1);
        idle(3);
        chk("t5_err_sticky", credit_err, 1'b1);

        // 6: asynchronous reset mid-stream, then fresh arbitration
        gap = 4'd3;
        for (int s = 0; s < 2; s++) begin
            ifc.flow_tx_in[2].valid = 1'b1;
            ifc.flow_tx_in[2].payload = mk(2, s);
            ifc.flow_tx_in[3].valid = 1'b1;
            ifc.flow_tx_in[3].payload = mk(3, s);
            idle(1);
            ifc.flow_tx_in = '0;
        end
        chk("t6_pre_valid", ifc.network_tx_out.valid, 1'b1);
        chk("t6_pre_flow", ifc.network_tx_out.payload[15:8], 8'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_async");
        @(posedge clk); #1;
        reset = 1'b0;
        lg.delete();
        gap = 4'd0;
        for (int f = 0; f < N; f++) begin
            ifc.flow_tx_in[f].valid = 1'b1;
            ifc.flow_tx_in[f].payload = mk(f, 7);
        end
        idle(1);
        ifc.flow_tx_in = '0;
        wait_issued("t6_issued", 4, 20);
        idle(3);
        chk("t6_only4", lg.size(), 4);
        if (lg.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t6_order", lg[i].p[15:0], {8'(i), 8'd7});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
